// File: rtl/mem_port_arbiter.sv
// Arbiter for one single-ported unified memory shared by the IF and MEM
// pipeline stages. Data accesses win by default. IF is forced after
// STARVE_MAX consecutive data wins taken against a pending fetch. Each
// access holds the memory for MEM_LAT cycles and then returns a single-cycle
// ready pulse to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dm,
  output logic              busy
);

  // MEM_LAT is at most 8, so the cycle counter never has to hold more than 7.
  localparam int CNT_W = 3;
  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);
  // A fetch is always a full-word load.
  localparam logic [2:0]       IF_FUNCT3  = 3'b010;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                grant_dm_q, grant_dm_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                pick_dm;

  // Saturating increment for the consecutive-data-win counter.
  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    if (v >= STARVE_LIM) return STARVE_LIM;
    else                 return v + 1'b1;
  endfunction

  // Next-state logic: grant in IDLE, count in ACCESS, return to IDLE after RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    grant_dm_d = grant_dm_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    pick_dm    = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          pick_dm    = dm_req && !(if_req && (starve_q == STARVE_LIM));
          grant_dm_d = pick_dm;
          cnt_d      = CNT_LOAD;
          state_d    = ACCESS;
          if (pick_dm) begin
            addr_d   = dm_addr;
            we_d     = dm_we;
            funct3_d = dm_funct3;
            wdata_d  = dm_wdata;
            starve_d = if_req ? sat_inc(starve_q) : '0;
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            funct3_d = IF_FUNCT3;
            wdata_d  = '0;
            starve_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Read data is valid only in the last access cycle.
          if (!we_q) begin
            if (grant_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      grant_dm_q <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      grant_dm_q <= grant_dm_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en     = (state_q == ACCESS);
  assign mem_we     = (state_q == ACCESS) && we_q;
  assign mem_funct3 = funct3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_ready   = (state_q == RESP) && !grant_dm_q;
  assign dm_ready   = (state_q == RESP) && grant_dm_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign grant_dm   = grant_dm_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=2 and
// STARVE_MAX=4, plus a MEM_LAT=1 instance for the minimum-latency case.
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        grant_dm;
  logic        busy;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic [31:0] if_rdata1;
  logic        if_ready1;
  logic [31:0] dm_rdata1;
  logic        dm_ready1;
  logic        mem_en1;
  logic        mem_we1;
  logic [2:0]  mem_funct31;
  logic [31:0] mem_addr1;
  logic [31:0] mem_wdata1;
  logic [31:0] mem_rdata1;
  logic        grant_dm1;
  logic        busy1;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant_dm(grant_dm), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(1'b0), .dm_we(1'b0), .dm_funct3(3'b000), .dm_addr(32'h0),
    .dm_wdata(32'h0), .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_funct3(mem_funct31), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .grant_dm(grant_dm1), .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL reset mem_en: got %b want 0", mem_en); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", busy); end
    vecs++; if ({if_ready, dm_ready, grant_dm, mem_we} !== 4'b0000) begin errs++; $display("FAIL reset ctl: got %b want 0000", {if_ready, dm_ready, grant_dm, mem_we}); end
    vecs++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_funct3 !== 3'b000) begin errs++; $display("FAIL reset mem regs: got %h/%h/%b want 0", mem_addr, mem_wdata, mem_funct3); end
    vecs++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errs++; $display("FAIL reset rdata: got %h/%h want 0", if_rdata, dm_rdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    int en_cnt = 0;
    int rdy_cyc = -1;
    mem_rdata = 32'h0050_0093;
    if_addr   = 32'h10;
    if_req    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (mem_en) en_cnt++;
      if (if_ready) begin
        if (rdy_cyc < 0) rdy_cyc = c;
        if_req = 1'b0;
      end
      if (c == 1) begin
        vecs++; if (mem_addr !== 32'h10 || mem_we !== 1'b0 || grant_dm !== 1'b0) begin errs++; $display("FAIL if_read access: got addr=%h we=%b g=%b want 10/0/0", mem_addr, mem_we, grant_dm); end
        vecs++; if (mem_funct3 !== 3'b010) begin errs++; $display("FAIL if_read funct3: got %b want 010", mem_funct3); end
      end
      vecs++; if (dm_ready !== 1'b0) begin errs++; $display("FAIL if_read dm_ready c%0d: got %b want 0", c, dm_ready); end
    end
    vecs++; if (en_cnt != 2) begin errs++; $display("FAIL if_read en cycles: got %0d want 2", en_cnt); end
    vecs++; if (rdy_cyc != 3) begin errs++; $display("FAIL if_read ready cycle: got %0d want 3", rdy_cyc); end
    vecs++; if (if_rdata !== 32'h0050_0093) begin errs++; $display("FAIL if_read rdata: got %h want 00500093", if_rdata); end
  endtask

  task automatic test_priority();
    mem_rdata = 32'hDEAD_0001;
    if_addr   = 32'h20;
    if_req    = 1'b1;
    dm_addr   = 32'h100;
    dm_we     = 1'b0;
    dm_funct3 = 3'b010;
    dm_req    = 1'b1;
    step();
    vecs++; if (grant_dm !== 1'b1 || mem_addr !== 32'h100) begin errs++; $display("FAIL prio first grant: got g=%b addr=%h want 1/100", grant_dm, mem_addr); end
    step();
    step();
    vecs++; if (dm_ready !== 1'b1 || if_ready !== 1'b0) begin errs++; $display("FAIL prio dm ready: got dm=%b if=%b want 1/0", dm_ready, if_ready); end
    vecs++; if (dm_rdata !== 32'hDEAD_0001) begin errs++; $display("FAIL prio dm_rdata: got %h want dead0001", dm_rdata); end
    dm_req    = 1'b0;
    mem_rdata = 32'hBEEF_0002;
    step();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL prio idle gap: got busy=%b want 0", busy); end
    step();
    vecs++; if (grant_dm !== 1'b0 || mem_addr !== 32'h20) begin errs++; $display("FAIL prio second grant: got g=%b addr=%h want 0/20", grant_dm, mem_addr); end
    step();
    step();
    vecs++; if (if_ready !== 1'b1 || dm_ready !== 1'b0) begin errs++; $display("FAIL prio if ready c7: got if=%b dm=%b want 1/0", if_ready, dm_ready); end
    vecs++; if (if_rdata !== 32'hBEEF_0002 || dm_rdata !== 32'hDEAD_0001) begin errs++; $display("FAIL prio rdata: got if=%h dm=%h want beef0002/dead0001", if_rdata, dm_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starve();
    logic exp_g;
    mem_rdata = 32'h0000_5555;
    if_addr   = 32'h30;
    dm_addr   = 32'h300;
    dm_we     = 1'b0;
    if_req    = 1'b1;
    dm_req    = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_g = (g == 4) ? 1'b0 : 1'b1;
      step();
      vecs++; if (grant_dm !== exp_g) begin errs++; $display("FAIL starve grant %0d: got %b want %b", g, grant_dm, exp_g); end
      step();
      step();
      vecs++; if (if_ready !== ~exp_g || dm_ready !== exp_g) begin errs++; $display("FAIL starve ready %0d: got if=%b dm=%b want %b/%b", g, if_ready, dm_ready, ~exp_g, exp_g); end
      if (g == 5) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_store();
    mem_rdata = 32'h0000_1234;
    dm_addr   = 32'h180;
    dm_we     = 1'b0;
    dm_funct3 = 3'b010;
    dm_req    = 1'b1;
    step();
    step();
    step();
    vecs++; if (dm_rdata !== 32'h1234) begin errs++; $display("FAIL store preload: got %h want 1234", dm_rdata); end
    dm_req = 1'b0;
    step();
    mem_rdata = 32'hFFFF_FFFF;
    dm_addr   = 32'h200;
    dm_we     = 1'b1;
    dm_funct3 = 3'b000;
    dm_wdata  = 32'hAB;
    dm_req    = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step();
      vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hAB) begin errs++; $display("FAIL store c%0d: got en=%b we=%b wd=%h want 1/1/ab", c, mem_en, mem_we, mem_wdata); end
      vecs++; if (mem_addr !== 32'h200 || mem_funct3 !== 3'b000) begin errs++; $display("FAIL store addr c%0d: got %h/%b want 200/000", c, mem_addr, mem_funct3); end
    end
    step();
    vecs++; if (dm_ready !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL store resp: got rdy=%b we=%b en=%b want 1/0/0", dm_ready, mem_we, mem_en); end
    vecs++; if (dm_rdata !== 32'h1234) begin errs++; $display("FAIL store rdata kept: got %h want 1234", dm_rdata); end
    dm_req = 1'b0;
    dm_we  = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    mem_rdata = 32'h0000_0055;
    if_addr   = 32'h40;
    if_req    = 1'b1;
    step();
    step();
    vecs++; if (mem_en !== 1'b1) begin errs++; $display("FAIL rstmid 2nd access: got en=%b want 1", mem_en); end
    reset = 1'b1;
    step();
    vecs++; if (mem_en !== 1'b0 || busy !== 1'b0 || if_ready !== 1'b0) begin errs++; $display("FAIL rstmid abort: got en=%b busy=%b rdy=%b want 0/0/0", mem_en, busy, if_ready); end
    vecs++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errs++; $display("FAIL rstmid rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    reset = 1'b0;
    step();
    vecs++; if (mem_en !== 1'b1 || mem_addr !== 32'h40 || if_ready !== 1'b0) begin errs++; $display("FAIL rstmid reissue: got en=%b addr=%h rdy=%b want 1/40/0", mem_en, mem_addr, if_ready); end
    step();
    step();
    vecs++; if (if_ready !== 1'b1 || if_rdata !== 32'h55) begin errs++; $display("FAIL rstmid served: got rdy=%b rdata=%h want 1/55", if_ready, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_lat1();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_0001;
    vals[1] = 32'h2222_0002;
    vals[2] = 32'h3333_0003;
    if_addr1 = 32'h80;
    if_req1  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata1 = vals[k];
      step();
      vecs++; if (mem_en1 !== 1'b1 || if_ready1 !== 1'b0) begin errs++; $display("FAIL lat1 access %0d: got en=%b rdy=%b want 1/0", k, mem_en1, if_ready1); end
      step();
      vecs++; if (mem_en1 !== 1'b0 || if_ready1 !== 1'b1 || dm_ready1 !== 1'b0) begin errs++; $display("FAIL lat1 resp %0d: got en=%b rdy=%b dm=%b want 0/1/0", k, mem_en1, if_ready1, dm_ready1); end
      vecs++; if (if_rdata1 !== vals[k]) begin errs++; $display("FAIL lat1 rdata %0d: got %h want %h", k, if_rdata1, vals[k]); end
      if (k == 2) if_req1 = 1'b0;
      step();
      vecs++; if (busy1 !== 1'b0 || if_ready1 !== 1'b0) begin errs++; $display("FAIL lat1 idle %0d: got busy=%b rdy=%b want 0/0", k, busy1, if_ready1); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_funct3  = '0;
    dm_addr    = '0;
    dm_wdata   = '0;
    mem_rdata  = '0;
    if_req1    = 1'b0;
    if_addr1   = '0;
    mem_rdata1 = '0;
    test_reset();
    test_if_read();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    test_lat1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage pipeline.
- Arbitrates competing requests. Data access has priority, and IF gets an anti-starvation override.
- Sequences multi-cycle memory accesses and returns read data with a one-cycle ready pulse; the pipeline stalls the requesting stage while its ready is low.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory access latency in cycles. Legal range 1..8.
- STARVE_MAX, 4, maximum consecutive data grants won against a pending IF request before IF is forced.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held until if_ready.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  DATA_W  fetched instruction, registered.
- if_ready  out  1  one-cycle completion pulse for IF.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_funct3  in  3  access size/sign, passed through to memory.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, registered.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  registered funct3.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle.
- grant_dm  out  1  owner of the current or last access: 1 = data, 0 = IF.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values: state = IDLE; all outputs 0, including rdata registers, mem_* registers, grant_dm, the latency counter and the starvation counter.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE; mem_en = 0.
- IDLE, request present:
  - Choose the winner (see Arbitration).
  - Latch the winner's addr, we (IF: we = 0) and funct3 (IF: 3'b010) into the mem_* registers; latch wdata (IF: 0).
  - Set grant_dm; load cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_we = latched we; mem_* outputs held stable.
  - cnt != 0: decrement cnt.
  - cnt == 0: on a read, capture mem_rdata into the owner's rdata register; go to RESP.
  - mem_en is high for exactly MEM_LAT cycles.
- RESP:
  - mem_en = 0 and mem_we = 0.
  - Assert the owner's ready for this single cycle; the other ready stays 0.
  - Go to IDLE; requests are ignored in RESP.
- Latency: from the edge that samples the request in IDLE, ready is high in cycle MEM_LAT+1 after that edge. Throughput is one access per MEM_LAT+2 cycles.
- Stores: dm_rdata is not updated. dm_ready still pulses.
- Requester handshake:
  - A requester keeps req and its operands stable until it sees ready.
  - It may drop req, or present a new request, on the edge ending the ready cycle.
  - Operand changes while req is high and not yet served are sampled only in IDLE.
- rdata registers hold their value until the next read completion for the same port.
- Arbitration:
  - Only dm_req: data wins.
  - Only if_req: IF wins.
  - Both: data wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- starve_cnt (sized to hold STARVE_MAX), updated only on IDLE grant decisions:
  - Data granted while if_req is high: increment, saturating at STARVE_MAX.
  - IF granted, or if_req low: clear to 0.
- Reset mid-operation: abort immediately. The state returns to IDLE, mem_en drops in the next cycle, and no ready pulse is issued for the aborted access; the requester must reissue.
- Address bits are not decoded or aligned in this block; funct3 is not interpreted.

Test Plan:
- MEM_LAT=2; IF-only read, if_addr=0x10, mem_rdata=0x00500093 in the last ACCESS cycle -> mem_en high 2 cycles with mem_addr=0x10, mem_we=0; if_ready pulses 1 cycle in cycle 3 after the sampling edge; if_rdata=0x00500093; dm_ready stays 0.
- Simultaneous if_req at 0x20 and dm load at 0x100 -> data served first (grant_dm=1, dm_ready pulse), then IF served at the next IDLE; total 8 cycles for both.
- Continuous dm_req plus if_req, STARVE_MAX=4 -> 4 data grants, 5th grant to IF, starve_cnt back to 0, then data resumes.
- Store, dm_we=1, dm_funct3=3'b000, addr 0x200, wdata 0xAB -> mem_we=1 with mem_wdata=0xAB for 2 cycles; dm_ready pulses; dm_rdata unchanged from its prior value 0x1234.
- Reset asserted during the 2nd ACCESS cycle -> next cycle mem_en=0, busy=0, no ready pulse, rdata registers 0; the held if_req is served afresh after reset is released.
- MEM_LAT=1 boundary -> mem_en high exactly 1 cycle; ready in cycle 2 after the sampling edge; back-to-back IF requests completed every 3 cycles.
